// File: rtl/vote_pkg.sv
// Shared definitions for the three-voter ballot session controller:
// FSM state encoding and voter count.
package vote_pkg;

    localparam int N_VOTERS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

endpackage

// File: rtl/vot3.sv
// Three-input majority gate: y is high when at least two inputs are high.
module vot3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot session sequencer around vot3: collects one vote per voter, closes
// on full quorum or timeout, shows the majority and keeps saturating tallies.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT  = 100,
    parameter int SHOW_CYC = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_val,
    input  logic                clr_cnt,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted,
    output logic                result,
    output logic                result_valid,
    output logic                timed_out,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic [CNT_W-1:0]    no_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int SHW_W = $clog2(SHOW_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state, state_nxt;
    logic [TMR_W-1:0]     timer;
    logic [SHW_W-1:0]     show_cnt;
    logic [N_VOTERS-1:0]  vote_q;
    logic [N_VOTERS-1:0]  accept;
    logic                 quorum, timer_last, show_last;
    logic                 open_sess, close_sess, decide;
    logic                 maj;

    assign quorum     = &(voted | vote_valid);
    assign timer_last = (timer == TMR_W'(TIMEOUT - 1));
    assign show_last  = (show_cnt == SHW_W'(SHOW_CYC - 1));

    // NOTE: async active-low reset; every register below uses <= so all
    // flops sample the same pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults assigned first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start)                state_nxt = ST_COLLECT;
            ST_COLLECT: if (quorum || timer_last) state_nxt = ST_DECIDE;
            ST_DECIDE:                            state_nxt = ST_SHOW;
            ST_SHOW:    if (show_last)            state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        open_sess  = 1'b0;
        close_sess = 1'b0;
        decide     = 1'b0;
        accept     = '0;
        case (state)
            ST_IDLE:    open_sess = start;
            ST_COLLECT: begin
                accept     = vote_valid & ~voted;
                close_sess = quorum || timer_last;
            end
            ST_DECIDE:  decide = 1'b1;
            default:    ;
        endcase
    end

    // Absent voters count as "no": only latched bits reach the gate.
    vot3 u_vot3 (
        .a (vote_q[0] & voted[0]),
        .b (vote_q[1] & voted[1]),
        .c (vote_q[2] & voted[2]),
        .y (maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            voted        <= '0;
            vote_q       <= '0;
            timer        <= '0;
            show_cnt     <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            busy         <= (state_nxt != ST_IDLE);
            result_valid <= decide;
            if (open_sess) begin
                voted     <= '0;
                vote_q    <= '0;
                timer     <= '0;
                result    <= 1'b0;
                timed_out <= 1'b0;
            end
            if (state == ST_COLLECT) begin
                voted  <= voted | accept;
                vote_q <= (vote_q & ~accept) | (vote_val & accept);
                if (close_sess) timed_out <= ~quorum;
                else            timer     <= timer + TMR_W'(1);
            end
            if (decide) begin
                result   <= maj;
                show_cnt <= '0;
            end
            if (state == ST_SHOW && !show_last) show_cnt <= show_cnt + SHW_W'(1);
        end
    end

    // A clear in the same cycle as a decision wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yes_cnt <= '0;
            no_cnt  <= '0;
        end else if (clr_cnt) begin
            yes_cnt <= '0;
            no_cnt  <= '0;
        end else if (decide) begin
            if (maj && yes_cnt != CNT_MAX)  yes_cnt <= yes_cnt + CNT_W'(1);
            if (!maj && no_cnt != CNT_MAX)  no_cnt  <= no_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: session-level reference model
// compared every cycle, directed scenarios with literal checks, random traffic.
module tb_vote_session_ctrl;

    localparam int TIMEOUT  = 100;
    localparam int SHOW_CYC = 8;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       vote_valid = '0;
    logic [2:0]       vote_val = '0;
    logic             clr_cnt = 1'b0;
    logic             busy, result, result_valid, timed_out;
    logic [2:0]       voted;
    logic [CNT_W-1:0] yes_cnt, no_cnt;

    int tot = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vote_session_ctrl #(
        .TIMEOUT (TIMEOUT),
        .SHOW_CYC(SHOW_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .vote_valid  (vote_valid),
        .vote_val    (vote_val),
        .clr_cnt     (clr_cnt),
        .busy        (busy),
        .voted       (voted),
        .result      (result),
        .result_valid(result_valid),
        .timed_out   (timed_out),
        .yes_cnt     (yes_cnt),
        .no_cnt      (no_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is "collecting" for up to TIMEOUT cycles,
    // then one decision cycle, then SHOW_CYC display cycles.
    bit         m_coll, m_dec;
    int         m_age, m_show, m_yes, m_no;
    logic [2:0] m_voted, m_val;
    logic       m_res, m_rv, m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_coll = 0; m_dec = 0; m_age = 0; m_show = 0; m_yes = 0; m_no = 0;
            m_voted = '0; m_val = '0; m_res = 0; m_rv = 0; m_to = 0;
        end else begin
            m_rv = 1'b0;
            if (m_coll) begin
                for (int i = 0; i < 3; i++)
                    if (vote_valid[i] && !m_voted[i]) begin
                        m_voted[i] = 1'b1;
                        m_val[i]   = vote_val[i];
                    end
                m_age++;
                if (m_voted == 3'b111) begin
                    m_coll = 0; m_dec = 1; m_to = 0;
                end else if (m_age == TIMEOUT) begin
                    m_coll = 0; m_dec = 1; m_to = 1;
                end
            end else if (m_dec) begin
                m_res = ($countones(m_val & m_voted) >= 2);
                m_rv  = 1'b1;
                if (m_res) m_yes = (m_yes < CNT_MAX) ? m_yes + 1 : CNT_MAX;
                else       m_no  = (m_no  < CNT_MAX) ? m_no  + 1 : CNT_MAX;
                m_dec  = 0;
                m_show = SHOW_CYC;
            end else if (m_show > 0) begin
                m_show--;
            end else if (start) begin
                m_coll = 1; m_age = 0; m_voted = '0; m_val = '0; m_res = 0; m_to = 0;
            end
            if (clr_cnt) begin
                m_yes = 0; m_no = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("busy",         busy,         m_coll || m_dec || (m_show > 0));
            check("voted",        voted,        m_voted);
            check("result",       result,       m_res);
            check("result_valid", result_valid, m_rv);
            check("timed_out",    timed_out,    m_to);
            check("yes_cnt",      yes_cnt,      m_yes);
            check("no_cnt",       no_cnt,       m_no);
        end
    end

    // Hold inputs across exactly one rising edge, then release them.
    task automatic step(input logic s, input logic [2:0] vv, input logic [2:0] vl, input logic c);
        start = s; vote_valid = vv; vote_val = vl; clr_cnt = c;
        @(posedge clk);
        #2;
        start = 0; vote_valid = '0; vote_val = '0; clr_cnt = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            step(0, 3'b000, 3'b000, 0);
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        while (!result_valid && n < 300) begin
            step(0, 3'b000, 3'b000, 0);
            n++;
        end
        check("wait_rv", result_valid, 1);
    endtask

    int n;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_voted", voted, 0);
        check("rst_yes", yes_cnt, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: votes 1,1,0 in collect cycles 2,3,5
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b000, 3'b000, 0);
        step(0, 3'b001, 3'b001, 0);
        step(0, 3'b010, 3'b010, 0);
        step(0, 3'b000, 3'b000, 0);
        step(0, 3'b100, 3'b000, 0);
        step(0, 3'b000, 3'b000, 0);
        check("t1_rv", result_valid, 1);
        check("t1_result", result, 1);
        check("t1_to", timed_out, 0);
        check("t1_yes", yes_cnt, 1);
        wait_idle();

        // 2: single yes vote, session times out
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b001, 3'b001, 0);
        wait_rv(n);
        check("t2_latency", n, TIMEOUT);
        check("t2_result", result, 0);
        check("t2_to", timed_out, 1);
        check("t2_voted", voted, 3'b001);
        check("t2_no", no_cnt, 1);
        wait_idle();

        // 3: voter 1 votes 0 then 1; voters 0 and 2 vote 1 together
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b000, 3'b000, 0);
        step(0, 3'b010, 3'b000, 0);
        step(0, 3'b000, 3'b000, 0);
        step(0, 3'b010, 3'b010, 0);
        step(0, 3'b101, 3'b101, 0);
        step(0, 3'b000, 3'b000, 0);
        check("t3_rv", result_valid, 1);
        check("t3_result", result, 1);
        check("t3_voted", voted, 3'b111);
        step(0, 3'b000, 3'b000, 0);
        check("t3_rv_single", result_valid, 0);
        wait_idle();

        // 4: votes in start cycle ignored, starts outside IDLE ignored
        step(1, 3'b111, 3'b111, 0);
        check("t4_voted_clear", voted, 0);
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b111, 3'b100, 0);
        step(0, 3'b000, 3'b000, 0);
        check("t4_rv", result_valid, 1);
        check("t4_result", result, 0);
        for (int k = 1; k < SHOW_CYC; k++) step(k[0], 3'b000, 3'b000, 0);
        check("t4_busy_show", busy, 1);
        step(1, 3'b000, 3'b000, 0);
        check("t4_idle", busy, 0);
        step(0, 3'b000, 3'b000, 0);
        check("t4_no_queue", busy, 0);

        // 5: yes tally saturates, then clear wins over a decision
        for (int s = 0; s < 260; s++) begin
            step(1, 3'b000, 3'b000, 0);
            step(0, 3'b111, 3'b111, 0);
            step(0, 3'b000, 3'b000, 0);
            wait_idle();
        end
        check("t5_sat", yes_cnt, CNT_MAX);
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b111, 3'b111, 0);
        step(0, 3'b000, 3'b000, 1);
        check("t5_clr_rv", result_valid, 1);
        check("t5_clr_yes", yes_cnt, 0);
        check("t5_clr_no", no_cnt, 0);
        wait_idle();

        // 6: reset pulse mid-collect with two votes latched
        step(0, 3'b000, 3'b000, 0);
        step(0, 3'b000, 3'b000, 0);
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b000, 3'b000, 0);
        step(0, 3'b011, 3'b011, 0);
        check("t6_pre_voted", voted, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_voted", voted, 0);
        check("t6_tally", {yes_cnt, no_cnt}, 0);
        #1 rst_n = 1'b1;
        step(1, 3'b000, 3'b000, 0);
        step(0, 3'b111, 3'b011, 0);
        wait_rv(n);
        check("t6_result", result, 1);
        check("t6_yes", yes_cnt, 1);
        wait_idle();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] vv;
            for (int b = 0; b < 3; b++) vv[b] = ($urandom_range(5) == 0);
            step($urandom_range(7) == 0, vv, 3'($urandom), $urandom_range(63) == 0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Sequences one three-voter ballot session around the existing vot3 majority gate. The block opens a session on start, latches at most one vote per voter, and closes on full quorum or timeout. It then computes the majority with absent voters counted as "no", presents the result for a fixed display window, and keeps saturating yes/no session tallies. It sits between the voter button front-end (already debounced) and the display/LED logic.

Parameters:
TIMEOUT, 100, maximum COLLECT cycles per session (>=2)
SHOW_CYC, 8, cycles spent in SHOW before returning to IDLE (>=1)
CNT_W, 8, width of the yes/no session tally counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  open session; honoured only in IDLE
vote_valid  input  3  bit i = voter i presents a vote this cycle
vote_val  input  3  bit i = voter i's value (1 = yes)
clr_cnt  input  1  synchronous clear of both tallies
busy  output  1  high in COLLECT, DECIDE, SHOW
voted  output  3  bit i = voter i's vote latched this session
result  output  1  majority decision of the last closed session
result_valid  output  1  one-cycle pulse when result updates
timed_out  output  1  last session closed without full quorum
yes_cnt  output  CNT_W  sessions decided yes, saturating
no_cnt  output  CNT_W  sessions decided no, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, voted, result, result_valid, timed_out, yes_cnt, no_cnt, vote latches, timer = 0.
- States: IDLE, COLLECT, DECIDE, SHOW; all outputs registered.
- IDLE: start=1 -> COLLECT next cycle; clears voted, vote latches, timer, result, timed_out at that edge. vote_valid is ignored in IDLE, including in the start cycle.
- COLLECT: for each i with vote_valid[i]=1 and voted[i]=0, latch vote_val[i] and set voted[i]. Later votes from the same voter are ignored, with no overwrite. Simultaneous votes from several voters are all accepted.
- COLLECT exit: if (voted | vote_valid)==3'b111 after the update -> DECIDE. Otherwise, if timer==TIMEOUT-1 -> DECIDE with timed_out=1. Otherwise timer+1.
- Timeout cycle: votes arriving in the cycle where timer==TIMEOUT-1 are accepted. If they complete quorum, timed_out=0.
- DECIDE (exactly 1 cycle): vot3 is fed the latched values, with non-voted bits forced to 0. At exit, register result, set result_valid=1, and increment yes_cnt or no_cnt (hold at 2^CNT_W-1). Go to SHOW.
- Latency: last vote presented in cycle N -> result_valid high in cycle N+2.
- SHOW: result_valid is high in the first SHOW cycle only. Stay SHOW_CYC cycles, then IDLE. result, timed_out and voted hold until the next start is accepted.
- start outside IDLE: ignored, with no queuing.
- clr_cnt: zeroes both tallies at the next edge. If it coincides with a DECIDE increment, the clear wins (tally = 0).
- Reset mid-session: immediate return to IDLE, with the session and tallies discarded.
- Timer width: clog2(TIMEOUT). SHOW counter width: clog2(SHOW_CYC+1).

Decomposition:
- Shared package vote_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_DECIDE=2'd2, ST_SHOW=2'd3;
  - voter count constant N_VOTERS=3.
- Sub-module: one instance of the existing vot3 majority gate, driven by the masked vote latches. No other sub-modules.

Test Plan:
1. Reset, start; votes 1,1,0 on voters 0,1,2 in COLLECT cycles 2,3,5 -> result_valid pulse 2 cycles after voter 2's vote, result=1, timed_out=0, yes_cnt=1.
2. Start; only voter 0 votes yes, TIMEOUT=100 -> DECIDE after COLLECT cycle 100, result=0, timed_out=1, voted=3'b001, no_cnt=1.
3. Start; voter 1 votes 0 then 1 on a later cycle; voters 0 and 2 vote 1 simultaneously -> voter 1 latched 0, result=1 (1,0,1), a single result_valid pulse.
4. Start with vote_valid=3'b111 in the same cycle, then start pulses during COLLECT and SHOW -> first-cycle votes ignored, extra starts ignored, busy stays 1 until SHOW_CYC=8 cycles after result_valid.
5. Run 260 yes sessions with CNT_W=8 -> yes_cnt saturates at 255. clr_cnt in the same cycle as a DECIDE -> yes_cnt=0.
6. Deassert rst_n for 1 ns mid-COLLECT with two votes latched -> busy, voted and tallies go to 0 immediately. A next start runs a clean session.
